// File: rtl/cg_rvarch_pkg.sv
// cg_rvarch_pkg: shared register-file writeback types and constants.
// Widths, writeback request bundle and source select encoding.
package cg_rvarch_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef enum logic {
    SRC0 = 1'b0,
    SRC1 = 1'b1
  } src_sel_e;

endpackage

// File: rtl/cg_rvarch_scoreboard.sv
// cg_rvarch_scoreboard: per-register pending-write busy bits.
// Ports: i_set_* marks a register busy, i_clr_* frees it, o_busy is the vector.
module cg_rvarch_scoreboard
  import cg_rvarch_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int DATA_NUM   = REG_NUM
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_set_en,
  input  logic [ADDR_WIDTH-1:0] i_set_addr,
  input  logic                  i_clr_en,
  input  logic [ADDR_WIDTH-1:0] i_clr_addr,
  output logic [DATA_NUM-1:0]   o_busy
);

  logic [DATA_NUM-1:0] r_busy;
  logic [DATA_NUM-1:0] w_next;

  // Set is applied after clear so a newer issue to the
  // register being retired keeps it busy.
  always_comb begin
    w_next = r_busy;
    if (i_clr_en)
      w_next[i_clr_addr] = 1'b0;
    if (i_set_en)
      w_next[i_set_addr] = 1'b1;
    w_next[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_busy <= '0;
    else
      r_busy <= w_next;
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/cg_rvarch_wb_arbiter.sv
// cg_rvarch_wb_arbiter: round-robin writeback arbiter driving the rd port.
// Ports: src0/src1 valid-ready results, issue dest, rd write port, busy vector.
module cg_rvarch_wb_arbiter
  import cg_rvarch_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int DATA_NUM   = REG_NUM
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_src0_valid,
  output logic                  o_src0_ready,
  input  logic [ADDR_WIDTH-1:0] i_src0_addr,
  input  logic [DATA_WIDTH-1:0] i_src0_data,
  input  logic                  i_src1_valid,
  output logic                  o_src1_ready,
  input  logic [ADDR_WIDTH-1:0] i_src1_addr,
  input  logic [DATA_WIDTH-1:0] i_src1_data,
  input  logic                  i_issue_valid,
  input  logic [ADDR_WIDTH-1:0] i_issue_addr,
  output logic                  o_rd_we,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [DATA_NUM-1:0]   o_busy
);

  src_sel_e              r_last;
  logic                  r_rd_we;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic    w_gnt0;
  logic    w_gnt1;
  logic    w_xfer;
  wb_req_t w_win;

  // r_last holds the most recent winner; on contention
  // the other source goes next.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!i_rst) begin
      w_gnt0 = i_src0_valid &&
               (!i_src1_valid || r_last == SRC1);
      w_gnt1 = i_src1_valid &&
               (!i_src0_valid || r_last == SRC0);
    end
  end

  assign w_xfer = w_gnt0 || w_gnt1;

  always_comb begin
    w_win.addr = i_src0_addr;
    w_win.data = i_src0_data;
    if (w_gnt1) begin
      w_win.addr = i_src1_addr;
      w_win.data = i_src1_data;
    end
  end

  // Reset to SRC1 so src0 wins the first contention.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_last <= SRC1;
    else if (w_gnt0)
      r_last <= SRC0;
    else if (w_gnt1)
      r_last <= SRC1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_we   <= 1'b0;
      r_rd_addr <= '0;
      r_rd_data <= '0;
    end else if (w_xfer) begin
      r_rd_we   <= (w_win.addr != '0);
      r_rd_addr <= w_win.addr;
      r_rd_data <= w_win.data;
    end else begin
      r_rd_we   <= 1'b0;
    end
  end

  cg_rvarch_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_NUM   (DATA_NUM)
  ) u_sb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_set_en   (i_issue_valid),
    .i_set_addr (i_issue_addr),
    .i_clr_en   (r_rd_we),
    .i_clr_addr (r_rd_addr),
    .o_busy     (o_busy)
  );

  assign o_src0_ready = w_gnt0;
  assign o_src1_ready = w_gnt1;
  assign o_rd_we      = r_rd_we;
  assign o_rd_addr    = r_rd_addr;
  assign o_rd_data    = r_rd_data;

endmodule

// File: tb/tb_cg_rvarch_wb_arbiter.sv
// tb_cg_rvarch_wb_arbiter: directed bench for the writeback arbiter.
// Inputs change on negedge; readies checked before, registers after posedge.
module tb_cg_rvarch_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        v0, v1;
  logic        r0, r1;
  logic [4:0]  a0, a1;
  logic [31:0] d0, d1;
  logic        iv;
  logic [4:0]  ia;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] busy;

  int checks   = 0;
  int failures = 0;

  cg_rvarch_wb_arbiter dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_src0_valid  (v0),
    .o_src0_ready  (r0),
    .i_src0_addr   (a0),
    .i_src0_data   (d0),
    .i_src1_valid  (v1),
    .o_src1_ready  (r1),
    .i_src1_addr   (a1),
    .i_src1_data   (d1),
    .i_issue_valid (iv),
    .i_issue_addr  (ia),
    .o_rd_we       (we),
    .o_rd_addr     (wa),
    .o_rd_data     (wd),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic rdy(input string tag,
                     input logic e0,
                     input logic e1);
    #1;
    chk({tag, "_rdy0"}, 64'(r0), 64'(e0));
    chk({tag, "_rdy1"}, 64'(r1), 64'(e1));
  endtask

  task automatic wport(input string tag,
                       input logic ew,
                       input logic [4:0] ea,
                       input logic [31:0] ed);
    chk({tag, "_we"}, 64'(we), 64'(ew));
    chk({tag, "_addr"}, 64'(wa), 64'(ea));
    chk({tag, "_data"}, 64'(wd), 64'(ed));
  endtask

  initial begin
    rst = 1'b1;
    v0 = 1'b0; v1 = 1'b0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    iv = 1'b0; ia = '0;

    // Reset: readies held low even with valids up.
    to_pos();
    to_pos();
    to_neg();
    v0 = 1'b1; v1 = 1'b1; a0 = 5'd1; a1 = 5'd3;
    rdy("rst", 1'b0, 1'b0);
    wport("rst", 1'b0, 5'd0, 32'h0);
    chk("rst_busy", 64'(busy), 64'h0);

    // src0 alone to x1.
    to_neg();
    rst = 1'b0;
    v1 = 1'b0;
    a0 = 5'd1; d0 = 32'h0000_0810;
    rdy("s0", 1'b1, 1'b0);
    to_pos();
    wport("s0", 1'b1, 5'd1, 32'h0000_0810);
    to_neg();
    v0 = 1'b0;
    rdy("s0idle", 1'b0, 1'b0);
    to_pos();
    wport("s0idle", 1'b0, 5'd1, 32'h0000_0810);

    // src1 alone to x4; leaves src1 as last winner.
    to_neg();
    v1 = 1'b1; a1 = 5'd4; d1 = 32'h44;
    rdy("s1", 1'b0, 1'b1);
    to_pos();
    wport("s1", 1'b1, 5'd4, 32'h44);

    // Both valid: expect src0, src1, src0, src1.
    to_neg();
    v0 = 1'b1; a0 = 5'd2; d0 = 32'h0514;
    v1 = 1'b1; a1 = 5'd3; d1 = 32'h0A0A;
    rdy("rr1", 1'b1, 1'b0);
    to_pos();
    wport("rr1", 1'b1, 5'd2, 32'h0514);
    to_neg();
    d0 = 32'h0515;
    rdy("rr2", 1'b0, 1'b1);
    to_pos();
    wport("rr2", 1'b1, 5'd3, 32'h0A0A);
    to_neg();
    d1 = 32'h0A0B;
    rdy("rr3", 1'b1, 1'b0);
    to_pos();
    wport("rr3", 1'b1, 5'd2, 32'h0515);
    to_neg();
    d0 = 32'h0516;
    rdy("rr4", 1'b0, 1'b1);
    to_pos();
    wport("rr4", 1'b1, 5'd3, 32'h0A0B);
    to_neg();
    v0 = 1'b0; v1 = 1'b0;
    to_pos();
    chk("rr_idle_we", 64'(we), 64'h0);

    // Busy set by issue, cleared at the commit edge.
    to_neg();
    iv = 1'b1; ia = 5'd5;
    to_pos();
    chk("iss_busy", 64'(busy), 64'h20);
    to_neg();
    iv = 1'b0;
    v1 = 1'b1; a1 = 5'd5; d1 = 32'h55;
    rdy("w5", 1'b0, 1'b1);
    to_pos();
    wport("w5", 1'b1, 5'd5, 32'h55);
    chk("w5_busy_hold", 64'(busy), 64'h20);
    to_neg();
    v1 = 1'b0;
    to_pos();
    chk("w5_busy_clr", 64'(busy), 64'h0);
    chk("w5_we_off", 64'(we), 64'h0);

    // Same-address set during the commit cycle wins.
    to_neg();
    iv = 1'b1; ia = 5'd5;
    to_pos();
    to_neg();
    iv = 1'b0;
    v1 = 1'b1; a1 = 5'd5; d1 = 32'h56;
    to_pos();
    wport("sw", 1'b1, 5'd5, 32'h56);
    to_neg();
    v1 = 1'b0;
    iv = 1'b1; ia = 5'd5;
    to_pos();
    chk("sw_busy", 64'(busy), 64'h20);

    // Different addresses: set x6 while x5 stays pending.
    to_neg();
    ia = 5'd6;
    to_pos();
    chk("set6_busy", 64'(busy), 64'h60);

    // x0: accepted, no write, no busy bit.
    to_neg();
    iv = 1'b1; ia = 5'd0;
    v0 = 1'b1; a0 = 5'd0; d0 = 32'hFFFF_FFFF;
    rdy("x0", 1'b1, 1'b0);
    to_pos();
    wport("x0", 1'b0, 5'd0, 32'hFFFF_FFFF);
    chk("x0_busy", 64'(busy), 64'h60);
    to_neg();
    iv = 1'b0; v0 = 1'b0;
    to_pos();
    chk("x0_busy2", 64'(busy), 64'h60);

    // Reset right after a handshake to x7.
    to_neg();
    v0 = 1'b1; a0 = 5'd7; d0 = 32'h77;
    iv = 1'b1; ia = 5'd9;
    to_pos();
    wport("pre", 1'b1, 5'd7, 32'h77);
    chk("pre_busy", 64'(busy), 64'h260);
    to_neg();
    rst = 1'b1;
    iv = 1'b0;
    v1 = 1'b1; a1 = 5'd8;
    rdy("mrst", 1'b0, 1'b0);
    to_pos();
    chk("mrst_we", 64'(we), 64'h0);
    chk("mrst_busy", 64'(busy), 64'h0);
    chk("mrst_addr", 64'(wa), 64'h0);

    // After reset src0 is preferred again.
    to_neg();
    rst = 1'b0;
    rdy("post", 1'b1, 1'b0);
    to_pos();
    wport("post", 1'b1, 5'd7, 32'h77);
    to_neg();
    v0 = 1'b0; v1 = 1'b0;
    to_pos();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
